// File: rtl/aes128_key_schedule.sv
// AES-128 round-key sequencer and store: expands a cipher key into rk[0..10], one
// round per clock, and serves round keys through a registered read port with zeroize.
module aes128_key_schedule #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             zeroize,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic             rd_en,
    input  logic [3:0]       rd_addr,
    output logic [KEY_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [3:0] MAX_IDX  = 4'(NUM_ROUNDS);
    localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

    state_t           state;
    logic [3:0]       round_cnt;
    logic [KEY_W-1:0] rk [0:NUM_ROUNDS];
    logic [KEY_W-1:0] next_key;
    logic             rd_ok;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // NOTE: blocking assignments are right inside functions and always_comb; only
    // the clocked state below uses non-blocking.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 via an addition chain; maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a3, a7, a15, a31, a63, a127;
        a3   = gf_mul(gf_mul(a, a), a);
        a7   = gf_mul(gf_mul(a3, a3), a);
        a15  = gf_mul(gf_mul(a7, a7), a);
        a31  = gf_mul(gf_mul(a15, a15), a);
        a63  = gf_mul(gf_mul(a31, a31), a);
        a127 = gf_mul(gf_mul(a63, a63), a);
        return gf_mul(a127, a127);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] count);
        case (count)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [KEY_W-1:0] key_expansion(input logic [KEY_W-1:0] key,
                                                       input logic [3:0]       count);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = key;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(count), 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        next_key = key_expansion(rk[round_cnt], round_cnt);
    end

    // Zeroize in the same cycle as a read must reject it, even with keys_valid still high.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_ok = 1'b0;
        if (keys_valid && !zeroize && (rd_addr <= MAX_IDX)) rd_ok = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            round_cnt  <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            // NOTE: the round-key store is cleared on reset on purpose: key material must
            // not survive a reset, so it lives in flops rather than an unreset RAM.
            for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
        end else begin
            done <= 1'b0;
            if (zeroize) begin
                state      <= IDLE;
                round_cnt  <= 4'd0;
                busy       <= 1'b0;
                keys_valid <= 1'b0;
                for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            rk[0]      <= key_in;
                            round_cnt  <= 4'd0;
                            state      <= EXPAND;
                            busy       <= 1'b1;
                            keys_valid <= 1'b0;
                        end
                    end
                    EXPAND: begin
                        rk[round_cnt + 4'd1] <= next_key;
                        round_cnt            <= round_cnt + 4'd1;
                        if (round_cnt == LAST_CNT) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            keys_valid <= 1'b1;
                            done       <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_en) begin
            if (rd_ok) begin
                rd_data  <= rk[rd_addr];
                rd_valid <= 1'b1;
                rd_err   <= 1'b0;
            end else begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
                rd_err   <= 1'b1;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Bench for aes128_key_schedule: word-level FIPS-197 key expansion model, scoreboard
// queues for reads and done pulses, and a negedge monitor that pops and compares.
module tb_aes128_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         zeroize;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rd_en;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_err;

    aes128_key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .zeroize    (zeroize),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    typedef struct packed {
        logic         valid;
        logic         err;
        logic [127:0] data;
        logic [31:0]  at;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    string       rd_name_q[$];
    logic [31:0] done_q[$];

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] m_keys [11];
    logic         m_valid;
    logic [127:0] pending_key;
    logic [127:0] last_data;
    logic [31:0]  exp_done_cyc;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
            sbox_t[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // ---------------- monitor ----------------
    rd_exp_t mon_e;
    string   mon_n;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_q.size() > 0 && rd_q[0].at == cyc) begin
                mon_e = rd_q.pop_front();
                mon_n = rd_name_q.pop_front();
                check({mon_n, "_valid"}, 128'(rd_valid), 128'(mon_e.valid));
                check({mon_n, "_err"}, 128'(rd_err), 128'(mon_e.err));
                check({mon_n, "_data"}, rd_data, mon_e.data);
            end else if (rd_valid) begin
                check("unexpected_rd_valid", 128'(rd_valid), 128'd0);
            end
            if (done) begin
                if (done_q.size() == 0) check("unexpected_done", 128'(done), 128'd0);
                else check("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
            end else if (done_q.size() > 0 && done_q[0] < cyc) begin
                check("done_missing_cycle", 128'(cyc), 128'(done_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [3:0] addr, input logic v, input logic e,
                             input logic [127:0] d, input string name);
        rd_exp_t x;
        x.valid = v;
        x.err   = e;
        x.data  = d;
        x.at    = cyc + 32'd1;
        rd_q.push_back(x);
        rd_name_q.push_back(name);
        last_data = d;
        rd_en   = 1'b1;
        rd_addr = addr;
    endtask

    task automatic issue_read(input logic [3:0] addr, input string name);
        logic ok;
        ok = m_valid && (addr <= 4'd10);
        push_read(addr, ok, !ok, ok ? m_keys[addr] : 128'h0, name);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic read_const(input logic [3:0] addr, input logic [127:0] d, input string name);
        push_read(addr, 1'b1, 1'b0, d, name);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic start_expand(input logic [127:0] key, input logic expect_done);
        key_in = key;
        start  = 1'b1;
        exp_done_cyc = cyc + 32'd11;
        if (expect_done) done_q.push_back(exp_done_cyc);
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        m_valid = 1'b0;
        pending_key = key;
        check("busy_after_start", 128'(busy), 128'd1);
        check("keys_valid_after_start", 128'(keys_valid), 128'd0);
    endtask

    task automatic finish_expand();
        while (cyc < exp_done_cyc) tick();
        check("keys_valid_after_done", 128'(keys_valid), 128'd1);
        check("busy_after_done", 128'(busy), 128'd0);
        model_expand(pending_key);
        m_valid = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; zeroize = 1'b0; rd_en = 1'b0;
        rd_addr = 4'd0; key_in = '0; m_valid = 1'b0; last_data = '0;
        build_sbox();
        #12;
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_keys_valid", 128'(keys_valid), 128'd0);
        check("reset_rd_valid", 128'(rd_valid), 128'd0);
        check("reset_rd_err", 128'(rd_err), 128'd0);
        check("reset_rd_data", rd_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // FIPS-197 vector, then read-port edge cases.
        start_expand(FIPS_KEY, 1'b1);
        finish_expand();
        read_const(4'd1, FIPS_RK1, "fips_rk1");
        read_const(4'd10, FIPS_RK10, "fips_rk10");
        read_const(4'd0, FIPS_KEY, "fips_rk0");
        issue_read(4'd11, "bad_addr11");
        tick();
        check("rd_err_sticky", 128'(rd_err), 128'd1);
        issue_read(4'd4, "good_after_err");
        tick();
        check("idle_rd_valid", 128'(rd_valid), 128'd0);
        check("idle_rd_data_hold", rd_data, last_data);

        // Second start during expansion is ignored.
        start_expand(128'h00112233445566778899aabbccddeeff, 1'b1);
        tick(); tick();
        key_in = 128'hffeeddccbbaa99887766554433221100;
        start = 1'b1;
        tick();
        start = 1'b0;
        issue_read(4'd3, "read_while_busy");
        finish_expand();
        issue_read(4'd10, "ignored_start_rk10");

        // Randomized keys with random reads, including bad addresses and idle gaps.
        for (int k = 0; k < 4; k++) begin
            start_expand({$urandom, $urandom, $urandom, $urandom}, 1'b1);
            finish_expand();
            for (int j = 0; j < 12; j++) begin
                issue_read(4'($urandom_range(0, 15)), "rand_read");
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                    check("rand_idle_rd_valid", 128'(rd_valid), 128'd0);
                    check("rand_idle_hold", rd_data, last_data);
                end
            end
        end

        // All-zero key.
        start_expand(128'h0, 1'b1);
        finish_expand();
        read_const(4'd1, ZERO_RK1, "zero_rk1");
        read_const(4'd10, ZERO_RK10, "zero_rk10");

        // Zeroize beats a read in the same cycle while keys are valid.
        zeroize = 1'b1;
        push_read(4'd5, 1'b0, 1'b1, 128'h0, "read_with_zeroize");
        tick();
        rd_en = 1'b0;
        zeroize = 1'b0;
        m_valid = 1'b0;
        check("zeroize_keys_valid", 128'(keys_valid), 128'd0);

        // Zeroize together with start mid-expansion: back to idle, no done.
        start_expand(FIPS_KEY, 1'b0);
        tick(); tick();
        zeroize = 1'b1;
        start = 1'b1;
        key_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        tick();
        zeroize = 1'b0;
        start = 1'b0;
        check("zs_busy", 128'(busy), 128'd0);
        check("zs_keys_valid", 128'(keys_valid), 128'd0);
        for (int i = 0; i < 12; i++) tick();
        check("zs_keys_valid_later", 128'(keys_valid), 128'd0);
        issue_read(4'd5, "zs_read5");

        // Async reset mid-expansion, then the FIPS vector again.
        start_expand(FIPS_KEY, 1'b1);
        finish_expand();
        issue_read(4'd0, "pre_reset_read");
        start_expand({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_done", 128'(done), 128'd0);
        check("arst_keys_valid", 128'(keys_valid), 128'd0);
        check("arst_rd_valid", 128'(rd_valid), 128'd0);
        check("arst_rd_err", 128'(rd_err), 128'd0);
        check("arst_rd_data", rd_data, 128'd0);
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_expand(FIPS_KEY, 1'b1);
        finish_expand();
        read_const(4'd1, FIPS_RK1, "post_reset_rk1");
        read_const(4'd10, FIPS_RK10, "post_reset_rk10");

        for (int i = 0; i < 4; i++) tick();
        check("read_queue_drained", 128'(rd_q.size()), 128'd0);
        check("done_queue_drained", 128'(done_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
